// File: rtl/sw_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the push-button front end (sw_pulse_gen):
//   - channel indices of the four board buttons
//   - repeat FSM state type
//   - default count constants for a 50 MHz system clock
//   - cnt_w(): counter width helper ($clog2 of the terminal value, minimum 1)
// Optional feature macro used by the importing files: SW_PULSE_REPEAT_EN.
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int SW_MODE  = 0;
  localparam int SW_POS   = 1;
  localparam int SW_INC   = 2;
  localparam int SW_ALARM = 3;

  localparam int DEF_DB_CNT     = 500_000;     // 10 ms
  localparam int DEF_LONG_CNT   = 50_000_000;  // 1 s
  localparam int DEF_REPEAT_CNT = 10_000_000;  // 200 ms

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_pulse_gen_db_cell.sv
// -----------------------------------------------------------------------------
// sw_db_cell
// One button channel: 2-flop synchroniser, counter debounce, press/release
// pulse generation and (optionally) hold-to-repeat.
// Optional feature macro: SW_PULSE_REPEAT_EN -- when defined and REPEAT_EN is
// set, a repeat FSM re-issues press pulses while the button stays held.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   i_sw_n     raw button, active-low, asynchronous to clk
//   o_level    debounced level, 1 = pressed
//   o_press    one-cycle pulse per accepted press (and per repeat)
//   o_release  one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module sw_db_cell
  import sw_pkg::*;
#(
  parameter int DB_CNT     = DEF_DB_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int DB_W = cnt_w(DB_CNT);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

  logic            sync1_q, sync2_q;
  logic            s;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            acc_press, acc_release;
  logic            rep_fire;

  // Synchronised, active-high button
  assign s = ~sync2_q;

  always_comb begin
    level_d     = level_q;
    db_cnt_d    = '0;
    acc_press   = 1'b0;
    acc_release = 1'b0;
    if (s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d     = s;
        acc_press   = s;
        acc_release = ~s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d   = acc_press | rep_fire;
    release_d = acc_release;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= i_sw_n;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef SW_PULSE_REPEAT_EN
  if (REPEAT_EN) begin : g_rpt
    localparam int HOLD_W = cnt_w((LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CNT - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CNT - 1);

    rpt_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              fire;

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      fire       = 1'b0;
      // A release always wins, even on a terminal-count cycle
      if (acc_release) begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (acc_press) begin
              state_d    = HOLD;
              hold_cnt_d = '0;
            end
          end
          HOLD: begin
            if (hold_cnt_q == LONG_LAST) begin
              fire       = 1'b1;
              hold_cnt_d = '0;
              state_d    = REPEAT;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (hold_cnt_q == REPEAT_LAST) begin
              fire       = 1'b1;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q    <= IDLE;
        hold_cnt_q <= '0;
      end else begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
      end
    end

    assign rep_fire = fire;
  end else begin : g_no_rpt
    assign rep_fire = 1'b0;
  end
`else
  logic unused_rep_en;
  assign unused_rep_en = REPEAT_EN;
  assign rep_fire      = 1'b0;
`endif

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: rtl/sw_pulse_gen.sv
// -----------------------------------------------------------------------------
// sw_pulse_gen
// Front-end conditioning for the board push-buttons: one sw_db_cell per
// channel. Outputs feed the clock controller's mode/position/increment/
// alarm-enable inputs (channel indices in sw_pkg).
// Optional feature macro: SW_PULSE_REPEAT_EN -- enables hold-to-repeat on
// the channels whose REPEAT_MASK bit is set; otherwise REPEAT_MASK is ignored.
// Ports:
//   clk           system clock (50 MHz)
//   rst_n         synchronous active-low reset
//   i_sw          raw buttons, active-low, asynchronous
//   o_sw_level    debounced levels, 1 = pressed
//   o_sw_press    one-cycle press pulses (plus repeats when enabled)
//   o_sw_release  one-cycle release pulses
// -----------------------------------------------------------------------------
module sw_pulse_gen
  import sw_pkg::*;
#(
  parameter int                NUM_SW      = 4,
  parameter int                DB_CNT      = DEF_DB_CNT,
  parameter int                LONG_CNT    = DEF_LONG_CNT,
  parameter int                REPEAT_CNT  = DEF_REPEAT_CNT,
  parameter logic [NUM_SW-1:0] REPEAT_MASK = 4'b0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] i_sw,
  output logic [NUM_SW-1:0] o_sw_level,
  output logic [NUM_SW-1:0] o_sw_press,
  output logic [NUM_SW-1:0] o_sw_release
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    sw_db_cell #(
      .DB_CNT     (DB_CNT),
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT),
      .REPEAT_EN  (REPEAT_MASK[i])
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sw_n    (i_sw[i]),
      .o_level   (o_sw_level[i]),
      .o_press   (o_sw_press[i]),
      .o_release (o_sw_release[i])
    );
  end

endmodule
